multicycle_controller: RTL and testbench

Multi-cycle control FSM for the core0 RISC-V datapath, succeeding the single-cycle decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states over one shared ALU and one shared instruction/data memory port. Memory latency is parametrised, and extended branches and SUB/SLT are configurable. Illegal opcodes drive the FSM into a sticky trap state.

---
 rtl/core0_pkg.sv | 63 ++++++
 rtl/alu_decoder.sv | 23 ++
 rtl/multicycle_controller.sv | 103 ++++++++++
 tb/tb_multicycle_controller.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core0_pkg.sv
// core0_pkg: shared state, opcode and datapath-select encodings for the core0 multicycle control path
package core0_pkg;
    typedef logic [3:0] state_t;
    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_FETCH    = 4'd1;
    localparam state_t S_DECODE   = 4'd2;
    localparam state_t S_MEMADR   = 4'd3;
    localparam state_t S_MEMREAD  = 4'd4;
    localparam state_t S_MEMWB    = 4'd5;
    localparam state_t S_MEMWRITE = 4'd6;
    localparam state_t S_EXECR    = 4'd7;
    localparam state_t S_EXECI    = 4'd8;
    localparam state_t S_ALUWB    = 4'd9;
    localparam state_t S_BRANCH   = 4'd10;
    localparam state_t S_JAL      = 4'd11;
    localparam state_t S_TRAP     = 4'd12;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef logic [2:0] alu_ctrl_t;
    localparam alu_ctrl_t ALU_ADD = 3'b000;
    localparam alu_ctrl_t ALU_SUB = 3'b001;
    localparam alu_ctrl_t ALU_AND = 3'b010;
    localparam alu_ctrl_t ALU_OR  = 3'b011;
    localparam alu_ctrl_t ALU_SLT = 3'b101;
    localparam alu_ctrl_t ALU_BAD = 3'b111;

    typedef logic [1:0] alu_op_t;
    localparam alu_op_t AOP_ADD = 2'b00;
    localparam alu_op_t AOP_SUB = 2'b01;
    localparam alu_op_t AOP_R   = 2'b10;
    localparam alu_op_t AOP_I   = 2'b11;

    typedef logic [1:0] result_src_t;
    localparam result_src_t RES_ALUOUT = 2'b00;
    localparam result_src_t RES_MEM    = 2'b01;
    localparam result_src_t RES_ALU    = 2'b10;

    typedef logic [1:0] src_a_t;
    localparam src_a_t SA_PC    = 2'b00;
    localparam src_a_t SA_OLDPC = 2'b01;
    localparam src_a_t SA_RS1   = 2'b10;

    typedef logic [1:0] src_b_t;
    localparam src_b_t SB_RS2  = 2'b00;
    localparam src_b_t SB_IMM  = 2'b01;
    localparam src_b_t SB_FOUR = 2'b10;

    typedef logic [1:0] imm_src_t;
    localparam imm_src_t IMM_I = 2'b00;
    localparam imm_src_t IMM_S = 2'b01;
    localparam imm_src_t IMM_B = 2'b10;
    localparam imm_src_t IMM_J = 2'b11;

    function automatic imm_src_t imm_of(logic [6:0] op);
        return op == OP_STORE ? IMM_S : op == OP_B ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
    endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps an ALU operation class and the function fields to an ALU control code
module alu_decoder
    import core0_pkg::*;
#(
    parameter int EXT_ALU = 1
) (
    input  alu_op_t    alu_op,
    input  logic [2:0] func3,
    input  logic       func7_5,
    output alu_ctrl_t  alu_ctrl,
    output logic       illegal
);
    alu_ctrl_t f_ctrl;
    // function-field decode for R/I classes; fixed add/sub for address and compare classes
    always_comb begin
        f_ctrl   = func3 == 3'b000 ? ((alu_op == AOP_R && func7_5) ? (EXT_ALU != 0 ? ALU_SUB : ALU_BAD) : ALU_ADD)
                 : func3 == 3'b111 ? ALU_AND
                 : func3 == 3'b110 ? ALU_OR
                 : (func3 == 3'b010 && EXT_ALU != 0) ? ALU_SLT : ALU_BAD;
        alu_ctrl = alu_op == AOP_ADD ? ALU_ADD : alu_op == AOP_SUB ? ALU_SUB : f_ctrl;
        illegal  = alu_ctrl == ALU_BAD;
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: fetch/decode/execute/memory/writeback sequencer for the core0 datapath
module multicycle_controller
    import core0_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int EXT_BRANCH = 1,
    parameter int EXT_ALU    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       func7_5,
    input  logic       alu_zero,
    input  logic       alu_lt,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_en,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       retire,
    output logic       illegal
);
    localparam int CW = $clog2(MEM_LAT + 1);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic last, multi, alu_bad, br_ok, take, bad;
    alu_op_t alu_op;
    alu_ctrl_t dec_ctrl;

    assign last   = cnt == CW'(MEM_LAT - 1);
    assign multi  = state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE;
    assign alu_op = op == OP_R ? AOP_R : op == OP_I ? AOP_I : op == OP_B ? AOP_SUB : AOP_ADD;
    assign br_ok  = func3 == 3'b000 || (EXT_BRANCH != 0 && (func3 == 3'b001 || func3 == 3'b100 || func3 == 3'b101));
    assign take   = (func3[2] ? alu_lt : alu_zero) ^ func3[0];
    assign bad    = op == OP_R || op == OP_I ? alu_bad
                  : op == OP_B ? !br_ok
                  : !(op == OP_LOAD || op == OP_STORE || op == OP_JAL);

    alu_decoder #(.EXT_ALU(EXT_ALU)) u_alu_dec (
        .alu_op  (alu_op),
        .func3   (func3),
        .func7_5 (func7_5),
        .alu_ctrl(dec_ctrl),
        .illegal (alu_bad)
    );

    // next-state selection; TRAP is absorbing until reset
    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE:                     state_nx = S_FETCH;
            S_FETCH:                    state_nx = last ? S_DECODE : S_FETCH;
            S_DECODE:                   state_nx = bad ? S_TRAP
                                                 : op == OP_LOAD || op == OP_STORE ? S_MEMADR
                                                 : op == OP_R ? S_EXECR
                                                 : op == OP_I ? S_EXECI
                                                 : op == OP_B ? S_BRANCH : S_JAL;
            S_MEMADR:                   state_nx = op == OP_LOAD ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:                  state_nx = last ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE:                 state_nx = last ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_JAL:    state_nx = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH: state_nx = S_FETCH;
            S_TRAP:                     state_nx = S_TRAP;
            default:                    state_nx = S_IDLE;
        endcase
    end

    // state register and memory-wait counter, cleared whenever a multi-cycle state is left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (multi && !last) ? cnt + 1'b1 : '0;
        end
    end

    // control outputs decoded from state, wait count and instruction fields
    always_comb begin
        ir_write   = state == S_FETCH && last;
        pc_write   = ir_write || state == S_JAL || (state == S_BRANCH && take);
        mem_en     = multi;
        adr_src    = state == S_MEMREAD || state == S_MEMWRITE;
        mem_write  = state == S_MEMWRITE && last;
        reg_write  = state == S_MEMWB || state == S_ALUWB;
        retire     = reg_write || mem_write || state == S_BRANCH;
        illegal    = state == S_TRAP;
        result_src = state == S_FETCH ? RES_ALU : state == S_MEMWB ? RES_MEM : RES_ALUOUT;
        alu_src_a  = state == S_FETCH ? SA_PC : (state == S_DECODE || state == S_JAL) ? SA_OLDPC : SA_RS1;
        alu_src_b  = (state == S_FETCH || state == S_JAL) ? SB_FOUR
                   : (state == S_EXECR || state == S_BRANCH) ? SB_RS2 : SB_IMM;
        alu_ctrl   = (state == S_EXECR || state == S_EXECI || state == S_BRANCH) ? dec_ctrl : ALU_ADD;
        imm_src    = imm_of(op);
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized checks of the multicycle control FSM against a phase-level model
module tb_multicycle_controller;
    typedef struct packed {
        logic       pc_write, adr_src, mem_en, mem_write, ir_write;
        logic [1:0] result_src, alu_src_a, alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] imm_src;
        logic       reg_write, retire, illegal;
    } out_t;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] RR = 7'b0110011;
    localparam logic [6:0] RI = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] JL = 7'b1101111;

    logic clk = 1'b0;
    logic [2:0] rst = 3'b000;
    logic [6:0] op = RR;
    logic [2:0] func3 = 3'b000;
    logic func7_5 = 1'b0, alu_zero = 1'b0, alu_lt = 1'b0;
    out_t [2:0] ov;
    out_t exp_q[$];
    out_t msk_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // instance g: MEM_LAT = g+1; instances 0 and 1 have both extensions, instance 2 has neither
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic pcw, adr, men, mw, irw, rw, ret, ill;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] ac;
        multicycle_controller #(.MEM_LAT(g + 1), .EXT_BRANCH(g < 2 ? 1 : 0), .EXT_ALU(g < 2 ? 1 : 0)) dut (
            .clk(clk), .rst_n(rst[g]), .op(op), .func3(func3), .func7_5(func7_5),
            .alu_zero(alu_zero), .alu_lt(alu_lt), .pc_write(pcw), .adr_src(adr), .mem_en(men),
            .mem_write(mw), .ir_write(irw), .result_src(rs), .alu_src_a(sa), .alu_src_b(sb),
            .alu_ctrl(ac), .imm_src(imm), .reg_write(rw), .retire(ret), .illegal(ill));
        assign ov[g] = {pcw, adr, men, mw, irw, rs, sa, sb, ac, imm, rw, ret, ill};
    end

    function automatic logic [1:0] imm_of(logic [6:0] o);
        return o == ST ? 2'b01 : o == BR ? 2'b10 : o == JL ? 2'b11 : 2'b00;
    endfunction

    // one expected cycle; a negative argument leaves that field unchecked
    function automatic void add(int pcw, int adr, int men, int mw, int irw, int rs, int sa, int sb,
                                int ac, int rw, int ret, int ill);
        out_t e, m;
        e = '0;
        m = '0;
        e.pc_write = pcw[0];     m.pc_write = pcw >= 0;
        e.adr_src = adr[0];      m.adr_src = adr >= 0;
        e.mem_en = men[0];       m.mem_en = men >= 0;
        e.mem_write = mw[0];     m.mem_write = mw >= 0;
        e.ir_write = irw[0];     m.ir_write = irw >= 0;
        e.result_src = rs[1:0];  m.result_src = {2{rs >= 0}};
        e.alu_src_a = sa[1:0];   m.alu_src_a = {2{sa >= 0}};
        e.alu_src_b = sb[1:0];   m.alu_src_b = {2{sb >= 0}};
        e.alu_ctrl = ac[2:0];    m.alu_ctrl = {3{ac >= 0}};
        e.reg_write = rw[0];     m.reg_write = rw >= 0;
        e.retire = ret[0];       m.retire = ret >= 0;
        e.illegal = ill[0];      m.illegal = ill >= 0;
        e.imm_src = imm_of(op);  m.imm_src = 2'b11;
        exp_q.push_back(e);
        msk_q.push_back(m);
    endfunction

    function automatic void add_idle();
        add(0, -1, 0, 0, 0, -1, -1, -1, -1, 0, 0, 0);
    endfunction

    // appends the cycle-by-cycle expectation of the current instruction; returns 1 if it traps
    function automatic bit build(int ml, bit eb, bit ea, int trap_len);
        bit legal, take;
        int fn;
        case (func3)
            3'b000:  fn = (op == RR && func7_5) ? (ea ? 1 : -1) : 0;
            3'b111:  fn = 2;
            3'b110:  fn = 3;
            3'b010:  fn = ea ? 5 : -1;
            default: fn = -1;
        endcase
        case (func3)
            3'b000:  take = alu_zero;
            3'b001:  take = !alu_zero;
            3'b100:  take = alu_lt;
            default: take = !alu_lt;
        endcase
        legal = op == LD || op == ST || op == JL || ((op == RR || op == RI) && fn >= 0)
             || (op == BR && (func3 == 3'b000 || (eb && (func3 == 3'b001 || func3 == 3'b100 || func3 == 3'b101))));
        for (int i = 0; i < ml; i++) add(i == ml - 1, 0, 1, 0, i == ml - 1, 2, 0, 2, 0, 0, 0, 0);
        add(0, -1, 0, 0, 0, -1, 1, 1, 0, 0, 0, 0);
        if (!legal) begin
            for (int i = 0; i < trap_len; i++) add(0, -1, 0, 0, 0, -1, -1, -1, -1, 0, 0, 1);
            return 1'b1;
        end
        if (op == LD || op == ST) begin
            add(0, -1, 0, 0, 0, -1, 2, 1, 0, 0, 0, 0);
            for (int i = 0; i < ml; i++)
                add(0, 1, 1, op == ST && i == ml - 1, 0, -1, -1, -1, -1, 0, op == ST && i == ml - 1, 0);
            if (op == LD) add(0, -1, 0, 0, 0, 1, -1, -1, -1, 1, 1, 0);
        end else if (op == BR) begin
            add(take, -1, 0, 0, 0, 0, 2, 0, 1, 0, 1, 0);
        end else begin
            if (op == JL) add(1, -1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
            else add(0, -1, 0, 0, 0, -1, 2, op == RR ? 0 : 1, fn, 0, 0, 0);
            add(0, -1, 0, 0, 0, 0, -1, -1, -1, 1, 1, 0);
        end
        return 1'b0;
    endfunction

    task automatic set_ir(logic [6:0] o, logic [2:0] f3, logic f7, logic z, logic l);
        op = o;
        func3 = f3;
        func7_5 = f7;
        alu_zero = z;
        alu_lt = l;
    endtask

    task automatic restart(int d);
        rst[d] = 1'b0;
        @(posedge clk);
        #2 rst[d] = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({ov[g].pc_write, ov[g].ir_write, ov[g].mem_write, ov[g].reg_write, ov[g].mem_en,
                 ov[g].retire, ov[g].illegal} !== 7'b0) begin
                errors++;
                $display("FAIL reset dut%0d outputs %h, strobes and illegal required 0", g, ov[g]);
            end
        end
    endtask

    task automatic test_alu_ops();
        logic [10:0] pat [7] = '{{RR, 3'b000, 1'b0}, {RR, 3'b000, 1'b1}, {RR, 3'b111, 1'b0},
                                 {RR, 3'b110, 1'b0}, {RR, 3'b010, 1'b0}, {RI, 3'b000, 1'b1},
                                 {RI, 3'b111, 1'b1}};
        out_t got;
        for (int k = 0; k < 7; k++) begin
            {op, func3, func7_5} = pat[k];
            exp_q.delete();
            msk_q.delete();
            if (k == 0) begin
                restart(0);
                add_idle();
            end
            void'(build(1, 1'b1, 1'b1, 0));
            foreach (exp_q[i]) begin
                @(negedge clk);
                got = ov[0];
                checks++;
                if ((got & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                    errors++;
                    $display("FAIL alu_ops instr %0d cycle %0d got %h want %h mask %h", k, i, got, exp_q[i], msk_q[i]);
                end
            end
        end
    endtask

    task automatic test_load();
        out_t got;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) set_ir(LD, 3'b010, 1'b0, 1'b0, 1'b0);
            else set_ir(RI, 3'b000, 1'b0, 1'b0, 1'b0);
            exp_q.delete();
            msk_q.delete();
            if (k == 0) begin
                restart(2);
                add_idle();
            end
            void'(build(3, 1'b0, 1'b0, 0));
            foreach (exp_q[i]) begin
                @(negedge clk);
                got = ov[2];
                checks++;
                if ((got & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                    errors++;
                    $display("FAIL load_lat3 instr %0d cycle %0d got %h want %h mask %h", k, i, got, exp_q[i], msk_q[i]);
                end
            end
        end
    endtask

    task automatic test_store();
        out_t got;
        int writes = 0;
        for (int k = 0; k < 2; k++) begin
            set_ir(ST, 3'b010, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            exp_q.delete();
            msk_q.delete();
            if (k == 0) begin
                restart(1);
                add_idle();
            end
            void'(build(2, 1'b1, 1'b1, 0));
            foreach (exp_q[i]) begin
                @(negedge clk);
                got = ov[1];
                writes += int'(got.mem_write);
                checks++;
                if ((got & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                    errors++;
                    $display("FAIL store_lat2 instr %0d cycle %0d got %h want %h mask %h", k, i, got, exp_q[i], msk_q[i]);
                end
            end
        end
        checks++;
        if (writes !== 2) begin
            errors++;
            $display("FAIL store_write_count got %0d want 2", writes);
        end
    endtask

    task automatic test_branch();
        logic [4:0] pat [6] = '{{3'b000, 1'b1, 1'b0}, {3'b001, 1'b1, 1'b0}, {3'b100, 1'b0, 1'b1},
                                {3'b101, 1'b0, 1'b1}, {3'b101, 1'b1, 1'b0}, {3'b000, 1'b0, 1'b1}};
        out_t got;
        for (int k = 0; k < 6; k++) begin
            op = BR;
            {func3, alu_zero, alu_lt} = pat[k];
            func7_5 = 1'($urandom_range(0, 1));
            exp_q.delete();
            msk_q.delete();
            if (k == 0) begin
                restart(0);
                add_idle();
            end
            void'(build(1, 1'b1, 1'b1, 0));
            foreach (exp_q[i]) begin
                @(negedge clk);
                got = ov[0];
                checks++;
                if ((got & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                    errors++;
                    $display("FAIL branch instr %0d cycle %0d got %h want %h mask %h", k, i, got, exp_q[i], msk_q[i]);
                end
            end
        end
    endtask

    task automatic test_jal();
        out_t got;
        for (int k = 0; k < 2; k++) begin
            set_ir(JL, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            exp_q.delete();
            msk_q.delete();
            if (k == 0) begin
                restart(1);
                add_idle();
            end
            void'(build(2, 1'b1, 1'b1, 0));
            foreach (exp_q[i]) begin
                @(negedge clk);
                got = ov[1];
                checks++;
                if ((got & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                    errors++;
                    $display("FAIL jal instr %0d cycle %0d got %h want %h mask %h", k, i, got, exp_q[i], msk_q[i]);
                end
            end
        end
    endtask

    task automatic test_trap();
        out_t got;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) set_ir(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
            else set_ir(BR, 3'b001, 1'b0, 1'b0, 1'b0);
            exp_q.delete();
            msk_q.delete();
            restart(k * 2);
            add_idle();
            void'(build(k * 2 + 1, k == 0, k == 0, k == 0 ? 20 : 5));
            foreach (exp_q[i]) begin
                @(negedge clk);
                got = ov[k * 2];
                checks++;
                if ((got & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                    errors++;
                    $display("FAIL trap case %0d cycle %0d got %h want %h mask %h", k, i, got, exp_q[i], msk_q[i]);
                end
            end
        end
        #2 rst[2] = 1'b0;
        #1;
        checks++;
        if (ov[2].illegal !== 1'b0) begin
            errors++;
            $display("FAIL trap_clear illegal got %b want 0", ov[2].illegal);
        end
    endtask

    task automatic test_async_reset();
        out_t got;
        set_ir(LD, 3'b010, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
        msk_q.delete();
        restart(2);
        add_idle();
        void'(build(3, 1'b0, 1'b0, 0));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            got = ov[2];
            checks++;
            if ((got & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                errors++;
                $display("FAIL async_pre cycle %0d got %h want %h mask %h", i, got, exp_q[i], msk_q[i]);
            end
        end
        #2 rst[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) #1;
            else @(negedge clk);
            got = ov[2];
            checks++;
            if ({got.pc_write, got.ir_write, got.mem_write, got.reg_write, got.mem_en, got.retire, got.illegal} !== 7'b0) begin
                errors++;
                $display("FAIL async_reset sample %0d got %h, strobes and illegal required 0", i, got);
            end
        end
        exp_q.delete();
        msk_q.delete();
        restart(2);
        add_idle();
        void'(build(3, 1'b0, 1'b0, 0));
        foreach (exp_q[i]) begin
            @(negedge clk);
            got = ov[2];
            checks++;
            if ((got & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                errors++;
                $display("FAIL async_recover cycle %0d got %h want %h mask %h", i, got, exp_q[i], msk_q[i]);
            end
        end
    endtask

    task automatic test_random();
        out_t got;
        logic [6:0] ops [7] = '{LD, ST, RR, RI, BR, JL, 7'b0001111};
        bit need_reset;
        for (int d = 0; d < 3; d++) begin
            need_reset = 1'b1;
            for (int k = 0; k < 40; k++) begin
                set_ir(ops[$urandom_range(0, 6)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                exp_q.delete();
                msk_q.delete();
                if (need_reset) begin
                    restart(d);
                    add_idle();
                end
                need_reset = build(d + 1, d < 2, d < 2, 4);
                foreach (exp_q[i]) begin
                    @(negedge clk);
                    got = ov[d];
                    checks++;
                    if ((got & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                        errors++;
                        $display("FAIL random dut%0d instr %0d op %b f3 %b cycle %0d got %h want %h mask %h",
                                 d, k, op, func3, i, got, exp_q[i], msk_q[i]);
                    end
                end
            end
            rst[d] = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_load();
        test_store();
        test_branch();
        test_jal();
        test_trap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout after 1000000 time units");
        $fatal(1);
    end
endmodule
